// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts up to FETCH_WIDTH sparse fetch slots per cycle
// into a circular buffer and issues the oldest entry to decode one per cycle.

package tortoise_pkg;
  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam int unsigned IFQ_DEPTH       = 8;

  typedef struct packed {
    logic        valid;
    logic [5:0]  cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } predict_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] instr;
    exception_t  ex;
    predict_t    predict;
  } fetch_entry_t;
endpackage

module fetch_queue
  import tortoise_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FETCH_WIDTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic         [FETCH_WIDTH-1:0] fetch_valid_i,
  input  fetch_entry_t [FETCH_WIDTH-1:0] fetch_entry_i,
  output logic                           fetch_ready_o,
  output fetch_entry_t                   issue_entry_o,
  output logic                           issue_valid_o,
  input  logic                           issue_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_WIDTH);

  // Handshakes: a fetch group is taken whenever fetch_ready_o is high (the
  // frontend holds its inputs otherwise); an entry leaves when
  // issue_valid_o && issue_ready_i are both high at a rising edge.

  fetch_entry_t     storage_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             push_en;
  logic             pop_en;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] slot_idx [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] slot_we;

  // Ready comes from the registered count only, so a same-cycle pop never helps.
  assign fetch_ready_o = (count_q <= READY_MAX);
  assign push_en       = fetch_ready_o;
  assign issue_valid_o = (count_q != '0);
  assign pop_en        = issue_valid_o && issue_ready_i;
  assign count_o       = count_q;

  always_comb begin
    issue_entry_o = '0;
    if (issue_valid_o) begin
      issue_entry_o       = storage_q[rd_ptr_q];
      issue_entry_o.valid = 1'b1;
    end
  end

  // Each valid slot lands at wr_ptr plus the number of valid slots below it,
  // which removes the gaps left by invalid slots.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_idx[i] = wr_ptr_q + PTR_W'(n_push);
      slot_we[i]  = push_en && fetch_valid_i[i];
      if (slot_we[i]) begin
        n_push = n_push + CNT_W'(1);
      end
    end
  end

  assign count_d = count_q + n_push - CNT_W'(pop_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        storage_q[j] <= '0;
      end
    end else if (flush_i) begin
      // Storage is left as is; with count at zero nothing in it is reachable.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (slot_we[i]) begin
          storage_q[slot_idx[i]] <= fetch_entry_i[i];
        end
      end
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, flow, compaction, full/wrap, flush and
// exception pass-through, with an expected-address queue for issue order.

module tb_fetch_queue;
  import tortoise_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic [1:0]         fetch_valid = '0;
  fetch_entry_t [1:0] fetch_entry = '0;
  logic               fetch_ready;
  fetch_entry_t       issue_entry;
  logic               issue_valid;
  logic               issue_ready = 1'b0;
  logic [3:0]         count;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  logic [31:0] exp_q[$];
  fetch_entry_t exc_entry;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  fetch_queue #(
    .DEPTH      (IFQ_DEPTH),
    .FETCH_WIDTH(INSTR_PER_FETCH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .fetch_valid_i(fetch_valid),
    .fetch_entry_i(fetch_entry),
    .fetch_ready_o(fetch_ready),
    .issue_entry_o(issue_entry),
    .issue_valid_o(issue_valid),
    .issue_ready_i(issue_ready),
    .count_o      (count)
  );

  function automatic fetch_entry_t mk(input logic [31:0] addr);
    fetch_entry_t e;
    e       = '0;
    e.valid = 1'b1;
    e.addr  = addr;
    e.instr = addr ^ 32'h0000_0013;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    fetch_valid    = v;
    fetch_entry[0] = mk(a0);
    fetch_entry[1] = mk(a1);
  endtask

  task automatic push(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    drive(v, a0, a1);
    if (v[0]) exp_q.push_back(a0);
    if (v[1]) exp_q.push_back(a1);
  endtask

  task automatic stop_fetch();
    fetch_valid = '0;
  endtask

  // scoreboard: the head shown this cycle must be the oldest expected address
  task automatic pop_check(input string tag);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check({tag, "_valid"}, 64'(issue_valid), 64'd1);
    check({tag, "_addr"}, 64'(issue_entry.addr), 64'(e));
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(issue_valid), 64'd0);
    check("rst_ready", 64'(fetch_ready), 64'd1);
    check("rst_addr", 64'(issue_entry.addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic flow
    push(2'b11, 32'h100, 32'h104);
    #1;
    check("no_bypass", 64'(issue_valid), 64'd0);
    tick();
    stop_fetch();
    issue_ready = 1'b1;
    check("basic_count", 64'(count), 64'd2);
    check("basic_head0", 64'(issue_entry.addr), 64'h100);
    pop_check("basic_pop0");
    tick();
    check("basic_head1", 64'(issue_entry.addr), 64'h104);
    pop_check("basic_pop1");
    tick();
    check("basic_empty_valid", 64'(issue_valid), 64'd0);
    check("basic_empty_addr", 64'(issue_entry.addr), 64'd0);
    tick();
    check("empty_pop_ignored", 64'(count), 64'd0);
    issue_ready = 1'b0;

    // compaction of sparse groups
    push(2'b10, 32'hDEAD_0000, 32'h204);
    tick();
    check("cmp_count1", 64'(count), 64'd1);
    check("cmp_head", 64'(issue_entry.addr), 64'h204);
    push(2'b01, 32'h208, 32'hDEAD_0004);
    tick();
    stop_fetch();
    check("cmp_count2", 64'(count), 64'd2);
    issue_ready = 1'b1;
    pop_check("cmp_pop0");
    tick();
    pop_check("cmp_pop1");
    tick();
    issue_ready = 1'b0;
    check("cmp_drained", 64'(count), 64'd0);

    // asynchronous reset with three entries queued
    push(2'b11, 32'h500, 32'h504);
    tick();
    push(2'b01, 32'h508, 32'h0);
    tick();
    stop_fetch();
    check("pre_rst_count", 64'(count), 64'd3);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_valid", 64'(issue_valid), 64'd0);
    check("async_rst_ready", 64'(fetch_ready), 64'd1);
    check("async_rst_addr", 64'(issue_entry.addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_release_count", 64'(count), 64'd0);

    // shift pointers to 1 so the last fill group straddles index 7 -> 0
    push(2'b01, 32'h600, 32'h0);
    tick();
    stop_fetch();
    issue_ready = 1'b1;
    pop_check("offset_pop");
    tick();
    issue_ready = 1'b0;

    // full and wrap
    push(2'b11, 32'h400, 32'h404);
    tick();
    push(2'b11, 32'h408, 32'h40C);
    tick();
    push(2'b11, 32'h410, 32'h414);
    tick();
    push(2'b11, 32'h418, 32'h41C);
    tick();
    stop_fetch();
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(fetch_ready), 64'd0);
    check("full_head", 64'(issue_entry.addr), 64'h400);
    drive(2'b11, 32'hBAD0, 32'hBAD4);
    tick();
    stop_fetch();
    check("full_ignore_count", 64'(count), 64'd8);
    issue_ready = 1'b1;
    pop_check("full_pop0");
    tick();
    pop_check("full_pop1");
    tick();
    pop_check("full_pop2");
    tick();
    issue_ready = 1'b0;
    check("after3_count", 64'(count), 64'd5);
    check("after3_head", 64'(issue_entry.addr), 64'h40C);
    push(2'b11, 32'h700, 32'h704);
    tick();
    stop_fetch();
    check("refill_count", 64'(count), 64'd7);
    check("refill_ready", 64'(fetch_ready), 64'd0);
    issue_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      pop_check($sformatf("wrap_pop%0d", k));
      tick();
    end
    issue_ready = 1'b0;
    check("wrap_drained", 64'(count), 64'd0);

    // simultaneous push and pop at count 6
    push(2'b11, 32'h800, 32'h804);
    tick();
    push(2'b11, 32'h808, 32'h80C);
    tick();
    push(2'b11, 32'h810, 32'h814);
    tick();
    stop_fetch();
    check("six_count", 64'(count), 64'd6);
    check("six_ready", 64'(fetch_ready), 64'd1);
    push(2'b11, 32'h818, 32'h81C);
    issue_ready = 1'b1;
    pop_check("six_pop");
    tick();
    stop_fetch();
    issue_ready = 1'b0;
    check("seven_count", 64'(count), 64'd7);
    check("seven_ready", 64'(fetch_ready), 64'd0);
    check("seven_head", 64'(issue_entry.addr), 64'h804);
    issue_ready = 1'b1;
    pop_check("to5_pop0");
    tick();
    pop_check("to5_pop1");
    tick();
    issue_ready = 1'b0;
    check("five_count", 64'(count), 64'd5);

    // flush beats a same-cycle push and pop
    flush = 1'b1;
    drive(2'b11, 32'hBAD8, 32'hBADC);
    issue_ready = 1'b1;
    tick();
    flush = 1'b0;
    stop_fetch();
    issue_ready = 1'b0;
    exp_q.delete();
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(issue_valid), 64'd0);
    check("flush_ready", 64'(fetch_ready), 64'd1);
    push(2'b01, 32'h300, 32'h0);
    tick();
    stop_fetch();
    check("post_flush_count", 64'(count), 64'd1);
    check("post_flush_head", 64'(issue_entry.addr), 64'h300);

    // exception and prediction fields pass through untouched
    exc_entry                = mk(32'h304);
    exc_entry.ex.valid       = 1'b1;
    exc_entry.ex.cause       = 6'd12;
    exc_entry.ex.tval        = 32'h0000_0304;
    exc_entry.predict.taken  = 1'b1;
    exc_entry.predict.target = 32'h0000_1000;
    fetch_entry[0] = exc_entry;
    fetch_valid    = 2'b01;
    exp_q.push_back(32'h304);
    issue_ready = 1'b1;
    pop_check("post_flush_pop");
    tick();
    stop_fetch();
    check("exc_ex_valid", 64'(issue_entry.ex.valid), 64'd1);
    check("exc_cause", 64'(issue_entry.ex.cause), 64'd12);
    check("exc_tval", 64'(issue_entry.ex.tval), 64'h304);
    check("exc_taken", 64'(issue_entry.predict.taken), 64'd1);
    check("exc_target", 64'(issue_entry.predict.target), 64'h1000);
    check("exc_instr", 64'(issue_entry.instr), 64'h317);
    total++;
    assert (issue_entry === exc_entry) passes++;
    else begin
      fails++;
      $error("FAIL exc_entry observed=%0h expected=%0h", issue_entry, exc_entry);
    end
    pop_check("exc_pop");
    tick();
    issue_ready = 1'b0;
    check("final_count", 64'(count), 64'd0);

    // final report
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
